imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Instruction assembler: the inverse of the ID-stage immediate generator.
- Takes decoded fields plus a 32-bit immediate and packs them into a 32-bit RV32I instruction word.
- Flags immediates that cannot be represented in the chosen format.
- Buffers results in a small output FIFO with valid/ready handshakes on both sides.
- Feeds the instruction-memory loader and the test/debug injector.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, ≥2)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  request present
in_ready  output  1  block accepts request this cycle
imm_type  input  3  format code from parameter.v: `R_TYPE, `I_TYPE, `S_TYPE, `B_TYPE, `J_TYPE, `U_TYPE
opcode  input  7  inst[6:0]
rd  input  5  inst[11:7] (R/I/U/J)
funct3  input  3  inst[14:12] (R/I/S/B)
rs1  input  5  inst[19:15] (R/I/S/B)
rs2  input  5  inst[24:20] (R/S/B)
funct7  input  7  inst[31:25] (R only)
imm  input  32  immediate in ID-stage ImmGen convention; B/J are halfword offsets (byte offset >> 1)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head
inst  output  32  encoded instruction at head
imm_err  output  1  head entry's immediate was not representable
err_cnt  output  ERR_W  accepted requests with imm_err=1, saturating

Behaviour:
- Handshake:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = !full, even if a pop occurs the same cycle; no full-bypass.
  - Inputs are sampled only on push.
- Latency: an entry pushed in cycle N is visible at the head (out_valid=1) in cycle N+1 if the FIFO was empty. Ordering is strict FIFO.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Pointer wrap: modulo DEPTH.
- Count: 0..DEPTH, with full = (count==DEPTH) and empty = (count==0).
- Encoding, computed combinationally at push and stored:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}. imm is ignored; never an error.
  - I: {imm[11:0],rs1,funct3,rd,opcode}. Error if imm[31:11] is not all equal.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}. Error rule as I.
  - B (imm = offset>>1, 12-bit signed):
    - inst[31] = imm[11]
    - inst[30:25] = imm[9:4]
    - inst[11:8] = imm[3:0]
    - inst[7] = imm[10]
    - inst[24:12] = {rs2,rs1,funct3}
    - inst[6:0] = opcode
    - Error if imm[31:11] is not all equal.
  - J (imm = offset>>1, 20-bit signed):
    - inst[31] = imm[19]
    - inst[19:12] = imm[18:11]
    - inst[20] = imm[10]
    - inst[30:21] = imm[9:0]
    - inst[11:7] = rd
    - inst[6:0] = opcode
    - Error if imm[31:19] is not all equal.
  - U: {imm[31:12],rd,opcode}. Error if imm[11:0] != 0.
  - Any other imm_type: inst=32'h0 and imm_err=1.
- Errored entries are still pushed with the truncated encoding above (except an unknown type, which gives 0). The consumer decides whether to drop them.
- err_cnt: increments on each push with imm_err=1 and saturates at all-ones.
- Round-trip invariant: for any non-error push, ImmGen(imm_type, inst) == imm.
- Reset (rstn=0 at an edge):
  - Pointers and count go to 0, so out_valid=0 and the FIFO is flushed.
  - err_cnt goes to 0.
  - in_ready=1 from the first cycle after reset deasserts.
  - inst and imm_err read as 0 while empty and after reset.
  - A reset mid-transfer discards all entries and ignores a concurrent push or pop.

Test Plan:
- Reset, then I-type (opcode 7'h13, rd=1, rs1=2, funct3=0, imm=32'hFFFFFFFF) -> next cycle out_valid=1, inst=32'hFFF10093, imm_err=0.
- B-type (opcode 7'h63, rs1=1, rs2=2, funct3=0, imm=32'h4, i.e. +8 bytes) -> inst=32'h00208463. Feed inst through ImmGen -> 32'h4.
- Range errors:
  - I imm=32'h800 -> imm_err=1.
  - U imm=32'h12345001 -> imm_err=1.
  - imm_type=3'b111 -> inst=0, imm_err=1.
  - err_cnt=3 after these three pushes.
- Backpressure: out_ready=0, push 5 requests with DEPTH=4 -> in_ready=0 after the 4th. Hold in_valid=1 with out_ready=1 for one cycle -> pop only, then the 5th is accepted. Order is preserved across wrap.
- Streaming: in_valid=out_ready=1 for 20 random requests -> one result per cycle, count stays at 1, and all non-error entries round-trip through ImmGen.
- Reset mid-stream: 3 entries queued, pull rstn=0 for one cycle with in_valid=1 -> out_valid=0, err_cnt=0, and the push is dropped.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs decoded fields and an immediate into an RV32I instruction word
// and queues it in a small FIFO, flagging immediates the chosen format cannot represent.
module imm_encoder #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_type,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             imm_err,
    output logic [ERR_W-1:0] err_cnt
);
    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] S_TYPE = 3'd2;
    localparam logic [2:0] B_TYPE = 3'd3;
    localparam logic [2:0] J_TYPE = 3'd4;
    localparam logic [2:0] U_TYPE = 3'd5;
    localparam int AW = $clog2(DEPTH);

    logic [31:0] enc;
    logic        enc_err;
    logic        fit12, fit20, u_ok;
    logic [31:0] mem_inst [DEPTH];
    logic        mem_err  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic push, pop;

    // B and J offsets arrive already halved, so the sign checks use the halfword widths
    assign fit12 = &imm[31:11] | ~|imm[31:11];
    assign fit20 = &imm[31:19] | ~|imm[31:19];
    assign u_ok  = ~|imm[11:0];

    always_comb begin
        enc = imm_type == R_TYPE ? {funct7, rs2, rs1, funct3, rd, opcode} :
              imm_type == I_TYPE ? {imm[11:0], rs1, funct3, rd, opcode} :
              imm_type == S_TYPE ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
              imm_type == B_TYPE ? {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode} :
              imm_type == J_TYPE ? {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode} :
              imm_type == U_TYPE ? {imm[31:12], rd, opcode} : 32'h0;
        enc_err = imm_type == R_TYPE ? 1'b0 :
                  (imm_type == I_TYPE || imm_type == S_TYPE || imm_type == B_TYPE) ? !fit12 :
                  imm_type == J_TYPE ? !fit20 :
                  imm_type == U_TYPE ? !u_ok : 1'b1;
    end

    assign out_valid = count != '0;
    assign in_ready  = count != (AW+1)'(DEPTH);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign inst      = out_valid ? mem_inst[rd_ptr] : 32'h0;
    assign imm_err   = out_valid ? mem_err[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push && enc_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_inst[wr_ptr] <= enc;
            mem_err[wr_ptr]  <= enc_err;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized checks of imm_encoder against a queue-based reference model
// that encodes from byte offsets and numeric ranges, plus an ImmGen decoder for round trips.
module tb_imm_encoder;
    localparam int DEPTH = 4;
    localparam logic [2:0] R_T = 3'd0, I_T = 3'd1, S_T = 3'd2, B_T = 3'd3, J_T = 3'd4, U_T = 3'd5;

    logic clk = 0, rstn = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, imm_err;
    logic [2:0] imm_type = 0, funct3 = 0;
    logic [6:0] opcode = 0, funct7 = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0, inst;
    logic [7:0] err_cnt;
    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [2:0]  t;
        logic [31:0] imm;
    } ent_t;
    ent_t mq[$];
    int mcnt = 0;

    imm_encoder #(.DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
        .imm_err(imm_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic ent_t model_enc();
        ent_t e;
        int s = imm;
        logic [31:0] off = imm << 1;
        e.t = imm_type;
        e.imm = imm;
        e.err = 1'b0;
        case (imm_type)
            R_T: e.inst = {funct7, rs2, rs1, funct3, rd, opcode};
            I_T: begin e.inst = {imm[11:0], rs1, funct3, rd, opcode}; e.err = s < -2048 || s > 2047; end
            S_T: begin e.inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; e.err = s < -2048 || s > 2047; end
            B_T: begin e.inst = {off[12], off[10:5], rs2, rs1, funct3, off[4:1], off[11], opcode}; e.err = s < -2048 || s > 2047; end
            J_T: begin e.inst = {off[20], off[10:1], off[11], off[19:12], rd, opcode}; e.err = s < -524288 || s > 524287; end
            U_T: begin e.inst = {imm[31:12], rd, opcode}; e.err = (imm % 4096) != 0; end
            default: begin e.inst = 32'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] immgen(input logic [2:0] t, input logic [31:0] w);
        case (t)
            I_T: return {{20{w[31]}}, w[31:20]};
            S_T: return {{20{w[31]}}, w[31:25], w[11:7]};
            B_T: return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
            J_T: return {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
            U_T: return {w[31:12], 12'h0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        bit p, q;
        ent_t e;
        p = in_valid && mq.size() < DEPTH;
        q = out_ready && mq.size() > 0;
        e = model_enc();
        @(posedge clk);
        if (!rstn) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (q) void'(mq.pop_front());
            if (p) begin
                mq.push_back(e);
                if (e.err && mcnt < 255) mcnt++;
            end
        end
        #1;
    endtask

    task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                           input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] im);
        imm_type = t; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = 7'h20; imm = im;
    endtask

    task automatic rand_req();
        logic [31:0] r = $urandom;
        imm_type = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 5));
        opcode = 7'($urandom); rd = 5'($urandom); funct3 = 3'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); funct7 = 7'($urandom);
        if ($urandom_range(0, 3) != 0)
            r = imm_type == J_T ? {{13{r[18]}}, r[18:0]} :
                imm_type == U_T ? {r[31:12], 12'h0} : {{21{r[10]}}, r[10:0]};
        imm = r;
    endtask

    task automatic test_reset();
        rstn = 0; in_valid = 1; out_ready = 0; set_req(I_T, 7'h13, 1, 0, 2, 0, 32'h5);
        step(); step();
        rstn = 1; in_valid = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (inst !== 32'h0 || imm_err !== 1'b0) begin bad++; $display("FAIL reset_head got=%h/%b exp=0/0", inst, imm_err); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_itype();
        set_req(I_T, 7'h13, 1, 0, 2, 0, 32'hFFFFFFFF); in_valid = 1; out_ready = 0;
        step(); in_valid = 0;
        total++; if (out_valid !== 1'b1 || inst !== 32'hFFF10093 || imm_err !== 1'b0) begin
            bad++; $display("FAIL itype got=%b/%h/%b exp=1/fff10093/0", out_valid, inst, imm_err); end
        out_ready = 1; step(); out_ready = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL itype_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_btype();
        set_req(B_T, 7'h63, 0, 0, 1, 2, 32'h4); in_valid = 1; out_ready = 0;
        step(); in_valid = 0;
        total++; if (inst !== 32'h00208463 || imm_err !== 1'b0) begin
            bad++; $display("FAIL btype got=%h/%b exp=00208463/0", inst, imm_err); end
        total++; if (immgen(B_T, inst) !== 32'h4) begin
            bad++; $display("FAIL btype_roundtrip got=%h exp=4", immgen(B_T, inst)); end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_errors();
        in_valid = 1; out_ready = 0;
        set_req(I_T, 7'h13, 3, 0, 4, 0, 32'h800); step();
        set_req(U_T, 7'h37, 5, 0, 0, 0, 32'h12345001); step();
        set_req(3'b111, 7'h33, 1, 1, 1, 1, 32'h0); step();
        in_valid = 0;
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL err_cnt got=%0d exp=3", err_cnt); end
        out_ready = 1;
        total++; if (inst !== 32'h80020193 || imm_err !== 1'b1) begin bad++; $display("FAIL err_i got=%h/%b exp=80020193/1", inst, imm_err); end
        step();
        total++; if (inst !== 32'h123452B7 || imm_err !== 1'b1) begin bad++; $display("FAIL err_u got=%h/%b exp=123452b7/1", inst, imm_err); end
        step();
        total++; if (inst !== 32'h0 || imm_err !== 1'b1) begin bad++; $display("FAIL err_type got=%h/%b exp=0/1", inst, imm_err); end
        step(); out_ready = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL err_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin rand_req(); step(); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        rand_req(); out_ready = 1; step();
        total++; if (in_ready !== 1'b1 || mq.size() != 3) begin
            bad++; $display("FAIL bp_pop_only in_ready=%b model_cnt=%0d exp=1/3", in_ready, mq.size()); end
        out_ready = 0; step(); in_valid = 0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_fifth got=%b exp=0", in_ready); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1 || inst !== mq[0].inst || imm_err !== mq[0].err) begin
                bad++; $display("FAIL bp_order%0d got=%h/%b exp=%h/%b", i, inst, imm_err, mq[0].inst, mq[0].err); end
            step();
        end
        total++; if (err_cnt !== 8'(mcnt)) begin bad++; $display("FAIL bp_err_cnt got=%0d exp=%0d", err_cnt, mcnt); end
        out_ready = 0;
    endtask

    task automatic test_stream();
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            rand_req(); step();
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || inst !== mq[0].inst || imm_err !== mq[0].err) begin
                bad++; $display("FAIL stream%0d got=%b/%b/%h/%b exp=1/1/%h/%b", i, out_valid, in_ready, inst, imm_err, mq[0].inst, mq[0].err); end
            if (!mq[0].err && mq[0].t != R_T) begin
                total++; if (immgen(mq[0].t, inst) !== mq[0].imm) begin
                    bad++; $display("FAIL stream_rt%0d got=%h exp=%h", i, immgen(mq[0].t, inst), mq[0].imm); end
            end
        end
        in_valid = 0; step();
        total++; if (out_valid !== 1'b0 || err_cnt !== 8'(mcnt)) begin
            bad++; $display("FAIL stream_end got=%b/%0d exp=0/%0d", out_valid, err_cnt, mcnt); end
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1; out_ready = 0;
        set_req(I_T, 7'h13, 1, 0, 2, 0, 32'h1000);
        for (int i = 0; i < 3; i++) step();
        total++; if (err_cnt === 8'd0) begin bad++; $display("FAIL mid_pre_cnt got=0 exp=nonzero"); end
        rstn = 0; out_ready = 1; step(); rstn = 1; in_valid = 0; out_ready = 0;
        total++; if (out_valid !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/1", out_valid, err_cnt, in_ready); end
        step();
        total++; if (out_valid !== 1'b0 || inst !== 32'h0) begin
            bad++; $display("FAIL mid_dropped got=%b/%h exp=0/0", out_valid, inst); end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_btype();
        test_errors();
        test_backpressure();
        test_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
